testdrive_axi_slave_ram: RTL and testbench

- Synthesizable, parametrised AXI slave with on-chip word RAM.
- Used as a self-contained memory endpoint when no host-side DPI model is attached.
- Independent write and read engines with full burst-type support (FIXED/INCR/WRAP) and per-beat error responses.
- Depth, data width, ID width and AXI3/AXI4 length format are parameters.

---
 rtl/testdrive_axi_slave_ram_if.sv | 54 +++++
 rtl/testdrive_axi_slave_ram.sv | 209 ++++++++++++++++++++
 tb/tb_testdrive_axi_slave_ram.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/testdrive_axi_slave_ram_if.sv
// rtl/testdrive_axi_slave_ram_if.sv - AXI bus bundle between a master and the RAM slave
interface testdrive_axi_slave_ram_if #(
    parameter int C_THREAD_ID_WIDTH = 1,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 32,
    parameter int C_USE_AXI4        = 1
);
    localparam int LEN_W  = (C_USE_AXI4 != 0) ? 8 : 4;
    localparam int STRB_W = C_DATA_WIDTH / 8;

    logic [C_THREAD_ID_WIDTH-1:0] AWID;
    logic [C_ADDR_WIDTH-1:0]      AWADDR;
    logic [LEN_W-1:0]             AWLEN;
    logic [1:0]                   AWBURST;
    logic                         AWVALID;
    logic                         AWREADY;
    logic [C_DATA_WIDTH-1:0]      WDATA;
    logic [STRB_W-1:0]            WSTRB;
    logic                         WLAST;
    logic                         WVALID;
    logic                         WREADY;
    logic [C_THREAD_ID_WIDTH-1:0] BID;
    logic [1:0]                   BRESP;
    logic                         BVALID;
    logic                         BREADY;
    logic [C_THREAD_ID_WIDTH-1:0] ARID;
    logic [C_ADDR_WIDTH-1:0]      ARADDR;
    logic [LEN_W-1:0]             ARLEN;
    logic [1:0]                   ARBURST;
    logic                         ARVALID;
    logic                         ARREADY;
    logic [C_THREAD_ID_WIDTH-1:0] RID;
    logic [C_DATA_WIDTH-1:0]      RDATA;
    logic [1:0]                   RRESP;
    logic                         RLAST;
    logic                         RVALID;
    logic                         RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
        input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input AWID, AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
        input WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input ARID, ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/testdrive_axi_slave_ram.sv
// rtl/testdrive_axi_slave_ram.sv - AXI slave endpoint backed by an on-chip word RAM
module testdrive_axi_slave_ram #(
    parameter int C_THREAD_ID_WIDTH = 1,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 32,
    parameter int C_MEM_DEPTH_LOG2  = 10,
    parameter int C_USE_AXI4        = 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    testdrive_axi_slave_ram_if.slave axi
);
    localparam int LEN_W     = (C_USE_AXI4 != 0) ? 8 : 4;
    localparam int STRB_W    = C_DATA_WIDTH / 8;
    localparam int OFFS      = $clog2(STRB_W);
    localparam int IDX_W     = C_ADDR_WIDTH - OFFS;
    localparam int MEM_WORDS = 1 << C_MEM_DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_e;

    // Unsupported burst encodings and non power-of-two WRAP lengths run as INCR with SLVERR
    function automatic logic burst_bad(input logic [1:0] burst, input logic [LEN_W-1:0] len);
        logic wrap_ok;
        wrap_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
        return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0]       burst,
                                                  input logic             bad,
                                                  input logic [LEN_W-1:0] len);
        logic [IDX_W-1:0] mask;
        mask = IDX_W'(len);
        if (!bad && burst == 2'b00) return idx;
        if (!bad && burst == 2'b10) return (idx & ~mask) | ((idx + IDX_W'(1)) & mask);
        return idx + IDX_W'(1);
    endfunction

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return (idx >> C_MEM_DEPTH_LOG2) == '0;
    endfunction

    logic [C_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // ---------------- write engine ----------------
    w_state_e                     w_state_q, w_state_d;
    logic [C_THREAD_ID_WIDTH-1:0] w_id_q;
    logic [IDX_W-1:0]             w_idx_q;
    logic [LEN_W-1:0]             w_len_q, w_cnt_q;
    logic [1:0]                   w_burst_q, w_resp_q, w_beat_resp;
    logic                         w_bad_q, aw_fire, w_fire, w_last_beat;

    assign aw_fire     = (w_state_q == W_IDLE) && axi.AWVALID;
    assign w_fire      = (w_state_q == W_DATA) && axi.WVALID;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_beat_resp = !in_range(w_idx_q) ? RESP_DECERR :
                         (w_bad_q || (axi.WLAST != w_last_beat)) ? RESP_SLVERR : RESP_OKAY;

    // Write FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) w_state_q <= W_INIT;
        else       w_state_q <= w_state_d;
    end

    // Write FSM next state; data phase ends on beat count, not on WLAST
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_INIT:  w_state_d = W_IDLE;
            W_IDLE:  if (aw_fire) w_state_d = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (axi.BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM handshake outputs
    always_comb begin
        axi.AWREADY = (w_state_q == W_IDLE);
        axi.WREADY  = (w_state_q == W_DATA);
        axi.BVALID  = (w_state_q == W_RESP);
        axi.BID     = w_id_q;
        axi.BRESP   = w_resp_q;
    end

    // Write burst bookkeeping: address walk, beat count and worst-case response
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_bad_q   <= 1'b0;
            w_resp_q  <= RESP_OKAY;
        end else if (aw_fire) begin
            w_id_q    <= axi.AWID;
            w_idx_q   <= IDX_W'(axi.AWADDR >> OFFS);
            w_len_q   <= axi.AWLEN;
            w_cnt_q   <= '0;
            w_burst_q <= axi.AWBURST;
            w_bad_q   <= burst_bad(axi.AWBURST, axi.AWLEN);
            w_resp_q  <= RESP_OKAY;
        end else if (w_fire) begin
            w_cnt_q <= w_cnt_q + LEN_W'(1);
            w_idx_q <= next_idx(w_idx_q, w_burst_q, w_bad_q, w_len_q);
            if (w_beat_resp > w_resp_q) w_resp_q <= w_beat_resp;
        end
    end

    // RAM byte-lane writes; out-of-range beats are dropped
    always_ff @(posedge CLK) begin
        if (w_fire && in_range(w_idx_q)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.WSTRB[b])
                    mem_q[w_idx_q[C_MEM_DEPTH_LOG2-1:0]][b*8 +: 8] <= axi.WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_e                     r_state_q, r_state_d;
    logic [C_THREAD_ID_WIDTH-1:0] r_id_q;
    logic [IDX_W-1:0]             r_idx_q;
    logic [LEN_W-1:0]             r_len_q, r_cnt_q;
    logic [1:0]                   r_burst_q, r_resp_q;
    logic                         r_bad_q, r_fetch_done_q;
    logic                         rvalid_q, rlast_q;
    logic [C_DATA_WIDTH-1:0]      rdata_q;
    logic                         ar_fire, r_take, r_load;

    assign ar_fire = (r_state_q == R_IDLE) && axi.ARVALID;
    assign r_take  = rvalid_q && axi.RREADY;
    // The RAM output register doubles as the R stage: refill it whenever it is empty or draining
    assign r_load  = (r_state_q == R_DATA) && !r_fetch_done_q && (!rvalid_q || axi.RREADY);

    // Read FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state_q <= R_INIT;
        else       r_state_q <= r_state_d;
    end

    // Read FSM next state; burst ends on the RLAST handshake
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_INIT:  r_state_d = R_IDLE;
            R_IDLE:  if (ar_fire) r_state_d = R_DATA;
            R_DATA:  if (r_take && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM handshake outputs
    always_comb begin
        axi.ARREADY = (r_state_q == R_IDLE);
        axi.RVALID  = rvalid_q;
        axi.RID     = r_id_q;
        axi.RDATA   = rdata_q;
        axi.RRESP   = r_resp_q;
        axi.RLAST   = rlast_q;
    end

    // Read burst fetch: synchronous RAM read straight into the R output register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_id_q         <= '0;
            r_idx_q        <= '0;
            r_len_q        <= '0;
            r_cnt_q        <= '0;
            r_burst_q      <= '0;
            r_bad_q        <= 1'b0;
            r_fetch_done_q <= 1'b0;
            rvalid_q       <= 1'b0;
            rlast_q        <= 1'b0;
            rdata_q        <= '0;
            r_resp_q       <= RESP_OKAY;
        end else begin
            if (ar_fire) begin
                r_id_q         <= axi.ARID;
                r_idx_q        <= IDX_W'(axi.ARADDR >> OFFS);
                r_len_q        <= axi.ARLEN;
                r_cnt_q        <= '0;
                r_burst_q      <= axi.ARBURST;
                r_bad_q        <= burst_bad(axi.ARBURST, axi.ARLEN);
                r_fetch_done_q <= 1'b0;
            end
            if (r_load) begin
                rvalid_q <= 1'b1;
                rdata_q  <= in_range(r_idx_q) ? mem_q[r_idx_q[C_MEM_DEPTH_LOG2-1:0]] : '0;
                r_resp_q <= !in_range(r_idx_q) ? RESP_DECERR :
                            r_bad_q ? RESP_SLVERR : RESP_OKAY;
                rlast_q  <= (r_cnt_q == r_len_q);
                r_cnt_q  <= r_cnt_q + LEN_W'(1);
                r_idx_q  <= next_idx(r_idx_q, r_burst_q, r_bad_q, r_len_q);
                if (r_cnt_q == r_len_q) r_fetch_done_q <= 1'b1;
            end else if (r_take) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_testdrive_axi_slave_ram.sv
// tb/tb_testdrive_axi_slave_ram.sv - scoreboard bench for the AXI slave RAM
module tb_testdrive_axi_slave_ram;
    localparam int IDW   = 2;
    localparam int DL2   = 5;
    localparam int WORDS = 1 << DL2;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    testdrive_axi_slave_ram_if #(.C_THREAD_ID_WIDTH(IDW), .C_ADDR_WIDTH(32),
                                 .C_DATA_WIDTH(32), .C_USE_AXI4(1)) axi ();

    testdrive_axi_slave_ram #(.C_THREAD_ID_WIDTH(IDW), .C_ADDR_WIDTH(32), .C_DATA_WIDTH(32),
                              .C_MEM_DEPTH_LOG2(DL2), .C_USE_AXI4(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .axi  (axi.slave)
    );

    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } rexp_t;

    bexp_t bexp_q[$];
    rexp_t rexp_q[$];
    logic [31:0] model [WORDS];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int  rr_pat[$];
    bit  rr_random = 0, b_random = 0, bready_hold = 0, gaps = 0;
    int  checks = 0, errors = 0, r_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---- reference model: burst rules in plain arithmetic ----
    function automatic bit burst_bad(input int len, input int burst);
        return (burst == 3) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic int beat_word(input int base, input int len, input int burst, input int i);
        int n, start;
        n = len + 1;
        if (burst == 0) return base;
        if (burst == 1 || burst_bad(len, burst)) return base + i;
        start = base - (base % n);
        return start + ((base - start + i) % n);
    endfunction

    function automatic int beat_resp(input int word, input bit bad);
        if (word >= WORDS) return 3;
        if (bad) return 2;
        return 0;
    endfunction

    // ---- ready drivers, updated away from the sampling edge ----
    initial begin
        axi.RREADY = 1'b0;
        axi.BREADY = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (rr_pat.size() > 0) axi.RREADY = (rr_pat.pop_front() != 0);
            else if (rr_random)    axi.RREADY = ($urandom_range(0, 3) != 0);
            else                   axi.RREADY = 1'b1;
            if (bready_hold)       axi.BREADY = 1'b0;
            else if (b_random)     axi.BREADY = ($urandom_range(0, 2) != 0);
            else                   axi.BREADY = 1'b1;
        end
    end

    // ---- monitor: pops expectations whenever the DUT completes a handshake ----
    initial begin
        bit    stalled;
        bexp_t be;
        rexp_t re;
        stalled = 0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                stalled = 0;
            end else begin
                if (axi.BVALID && axi.BREADY) begin
                    if (bexp_q.size() == 0) fail_now("b_unexpected");
                    else begin
                        be = bexp_q.pop_front();
                        check("bid", axi.BID, be.id);
                        check("bresp", axi.BRESP, be.resp);
                    end
                end
                if (stalled) check("rvalid_hold", axi.RVALID, 1'b1);
                if (axi.RVALID) begin
                    if (rexp_q.size() == 0) fail_now("r_unexpected");
                    else if (!axi.RREADY) begin
                        check("rdata_stall", axi.RDATA, rexp_q[0].data);
                        check("rlast_stall", axi.RLAST, rexp_q[0].last);
                    end else begin
                        re = rexp_q.pop_front();
                        check("rdata", axi.RDATA, re.data);
                        check("rresp", axi.RRESP, re.resp);
                        check("rlast", axi.RLAST, re.last);
                        check("rid", axi.RID, re.id);
                        r_seen++;
                    end
                end
                stalled = axi.RVALID && !axi.RREADY;
            end
        end
    end

    task automatic wait_ready(input int which, input string name);
        int  k;
        bit  hit;
        hit = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (which == 0) hit = axi.AWREADY;
            else if (which == 1) hit = axi.WREADY;
            else hit = axi.ARREADY;
            if (hit) break;
        end
        if (!hit) fail_now({name, "_timeout"});
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int id, input int addr, input int len, input int burst,
                            input int wlast_at);
        int    base, w, r, worst;
        bit    bad;
        bexp_t be;
        base  = addr >> 2;
        bad   = burst_bad(len, burst);
        worst = 0;
        for (int i = 0; i <= len; i++) begin
            w = beat_word(base, len, burst, i);
            r = beat_resp(w, bad);
            if (r > worst) worst = r;
            if (w < WORDS)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[w][b*8 +: 8] = wd[i][b*8 +: 8];
        end
        if (wlast_at != len && worst < 2) worst = 2;
        be.id   = id[IDW-1:0];
        be.resp = worst[1:0];
        bexp_q.push_back(be);

        axi.AWID    = id[IDW-1:0];
        axi.AWADDR  = addr;
        axi.AWLEN   = len[7:0];
        axi.AWBURST = burst[1:0];
        axi.AWVALID = 1'b1;
        wait_ready(0, "aw");
        axi.AWVALID = 1'b0;
        check("wready_latency", axi.WREADY, 1'b1);
        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    axi.WVALID = 1'b0;
                    @(posedge CLK);
                    #1;
                end
            end
            axi.WDATA  = wd[i];
            axi.WSTRB  = ws[i];
            axi.WLAST  = (i == wlast_at);
            axi.WVALID = 1'b1;
            wait_ready(1, "w");
            axi.WVALID = 1'b0;
            axi.WLAST  = 1'b0;
        end
        check("bvalid_latency", axi.BVALID, 1'b1);
    endtask

    task automatic do_read(input int id, input int addr, input int len, input int burst);
        int    base, w;
        bit    bad;
        rexp_t re;
        base = addr >> 2;
        bad  = burst_bad(len, burst);
        for (int i = 0; i <= len; i++) begin
            w       = beat_word(base, len, burst, i);
            re.resp = beat_resp(w, bad);
            re.data = (w < WORDS) ? model[w] : 32'h0;
            re.last = (i == len);
            re.id   = id[IDW-1:0];
            rexp_q.push_back(re);
        end
        axi.ARID    = id[IDW-1:0];
        axi.ARADDR  = addr;
        axi.ARLEN   = len[7:0];
        axi.ARBURST = burst[1:0];
        axi.ARVALID = 1'b1;
        wait_ready(2, "ar");
        axi.ARVALID = 1'b0;
        check("rvalid_latency_1", axi.RVALID, 1'b0);
        @(posedge CLK);
        #1;
        check("rvalid_latency_2", axi.RVALID, 1'b1);
    endtask

    task automatic drain();
        int k;
        bit done;
        done = 0;
        for (k = 0; k < 2000; k++) begin
            @(negedge CLK);
            if (bexp_q.size() == 0 && rexp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            fail_now("drain_timeout");
            bexp_q.delete();
            rexp_q.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, len, burst, addr, id, wl, start;
        bit seen;
        axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0;
        axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARBURST = '0; axi.ARVALID = 1'b0;

        // reset values
        repeat (2) @(negedge CLK);
        check("rst_awready", axi.AWREADY, 1'b0);
        check("rst_arready", axi.ARREADY, 1'b0);
        check("rst_ready_valid", {axi.WREADY, axi.BVALID, axi.RVALID, axi.RLAST}, 4'b0);
        check("rst_resp_id", {axi.BRESP, axi.RRESP, axi.BID, axi.RID}, '0);
        check("rst_rdata", axi.RDATA, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        check("awready_before_edge", axi.AWREADY, 1'b0);
        @(posedge CLK);
        #1;
        check("awready_after_edge", axi.AWREADY, 1'b1);
        check("arready_after_edge", axi.ARREADY, 1'b1);

        // fill the whole RAM
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(0, blk * 64, 15, 1, 15);
            drain();
        end

        // INCR write then readback
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * (i + 1); ws[i] = 4'hF; end
        do_write(1, 32'h40, 3, 1, 3);
        drain();
        do_read(1, 32'h40, 3, 1);
        drain();

        // WRAP read, then illegal WRAP length
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 4); ws[i] = 4'hF; end
        do_write(0, 32'h10, 3, 1, 3);
        drain();
        do_read(2, 32'h18, 3, 2);
        drain();
        do_read(3, 32'h18, 2, 2);
        drain();

        // byte strobes, early WLAST, FIXED write
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(0, 32'h28, 0, 1, 0);
        drain();
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'h1;
        do_write(0, 32'h28, 0, 1, 0);
        drain();
        do_read(0, 32'h28, 0, 1);
        drain();
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'(i + 12); end
        do_write(1, 32'h30, 3, 1, 1);
        drain();
        do_write(2, 32'h50, 3, 0, 3);
        drain();

        // crossing the end of the RAM
        do_read(0, 32'h78, 3, 1);
        drain();
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(2, 32'h74, 3, 1, 3);
        drain();
        do_read(1, 32'h70, 3, 1);
        drain();

        // RREADY stall pattern and held write response
        rr_pat = '{1, 1, 1, 0, 0, 1};
        do_read(1, 32'h40, 3, 1);
        drain();
        bready_hold = 1;
        do_write(1, 32'h20, 1, 1, 1);
        repeat (5) begin
            @(negedge CLK);
            check("bvalid_held", axi.BVALID, 1'b1);
            check("awready_held", axi.AWREADY, 1'b0);
        end
        bready_hold = 0;
        drain();

        // reset in the middle of a read burst
        start = r_seen;
        do_read(2, 32'h0, 7, 1);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (r_seen >= start + 2) begin seen = 1; break; end
        end
        if (!seen) fail_now("midread_wait_timeout");
        #1;
        nRST = 1'b0;
        #1;
        check("midrst_rvalid", axi.RVALID, 1'b0);
        check("midrst_rdata", axi.RDATA, 32'h0);
        check("midrst_arready", axi.ARREADY, 1'b0);
        rexp_q.delete();
        bexp_q.delete();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        do_read(2, 32'h0, 7, 1);
        drain();

        // randomized traffic
        rr_random = 1;
        b_random  = 1;
        gaps      = 1;
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            id = $urandom_range(0, 3);
            if (op == 0) begin
                len   = $urandom_range(0, 15);
                burst = $urandom_range(0, 3);
                addr  = $urandom_range(0, 32'h9F);
                wl    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : len;
                do_write(id, addr, len, burst, wl);
            end else if (op == 1) begin
                len   = $urandom_range(0, 15);
                burst = $urandom_range(0, 3);
                addr  = $urandom_range(0, 32'h9F);
                do_read(id, addr, len, burst);
            end else begin
                len = $urandom_range(0, 3);
                fork
                    do_write(id, $urandom_range(0, 32'h2F), len, 1, len);
                    do_read(3 - id, $urandom_range(32'h50, 32'h7F), $urandom_range(0, 7),
                            $urandom_range(0, 3));
                join
            end
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
